// File: rtl/clk_div_mon_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_mon_pkg                                               |
// | Purpose  : Shared types and constants for the divided-clock monitor.     |
// |            Holds the monitor FSM state encoding and the default number   |
// |            of consecutive good periods needed to declare lock.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package clk_div_mon_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    SEEK   = 2'd0,  // waiting for the first rising edge of mon_clk
    MEAS   = 2'd1,  // measuring periods, not yet locked
    LOCKED = 2'd2   // LOCK_CNT consecutive good periods seen
  } mon_state_t;

  // Default number of consecutive good periods before lock is declared
  localparam int LOCK_CNT_DEFAULT = 4;

endpackage : clk_div_mon_pkg
`default_nettype wire

// File: rtl/clk_edge_det.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_edge_det                                                  |
// | Purpose  : Single-register edge detector for a signal that is already    |
// |            synchronous to clk (no synchronizer stage).                   |
// | Ports    : clk   in  - reference clock, rising edge                      |
// |            rst_n in  - asynchronous active-low reset                     |
// |            sig   in  - signal to watch                                   |
// |            rise  out - high in the cycle where sig goes 0 -> 1           |
// |            fall  out - high in the cycle where sig goes 1 -> 0           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= sig;
    end
  end

  // Previous value resets to 0, so a signal that is high when reset is
  // released reports a rise on the first clock.
  assign rise = sig & ~r_prev;
  assign fall = ~sig & r_prev;

endmodule : clk_edge_det
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_monitor                                               |
// | Purpose  : Health monitor for a divided clock generated synchronously    |
// |            from clk. Measures period and high time of mon_clk in clk     |
// |            cycles, checks them against DIV, reports lock and errors.     |
// | Params   : DIV      - expected divide ratio (>= 2)                       |
// |            LOCK_CNT - consecutive good periods needed for lock (>= 1)    |
// |            CNT_W    - counter / result width                             |
// | Ports    : clk        in  - reference clock                              |
// |            rst_n      in  - asynchronous active-low reset                |
// |            mon_clk    in  - divided clock under test                     |
// |            meas_valid out - 1-cycle pulse, new measurement available     |
// |            period     out - last measured period                         |
// |            high_time  out - last measured high time                      |
// |            locked     out - LOCK_CNT consecutive good periods seen       |
// |            err        out - 1-cycle pulse on bad period or timeout       |
// |            err_sticky out - set by any err, cleared by reset only        |
// | Macro    : CLK_DIV_MON_DUTY_CHECK_EN - when defined, a good period must  |
// |            also have high_time == DIV/2 (DIV/2+1 also for odd DIV).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int DIV      = 6,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT,
  parameter int CNT_W    = $clog2(2*DIV+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err,
  output logic             err_sticky
);

  localparam int               c_GOOD_W  = $clog2(LOCK_CNT+1);
  localparam logic [CNT_W-1:0] c_DIV     = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(2*DIV);
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] c_HALF_LO = CNT_W'(DIV/2);
  localparam logic [CNT_W-1:0] c_HALF_HI = CNT_W'((DIV % 2 == 1) ? (DIV/2 + 1) : (DIV/2));
`endif
  localparam logic [c_GOOD_W-1:0] c_LOCK_M1 = c_GOOD_W'(LOCK_CNT-1);

  mon_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_hcnt, w_hcnt_nxt;
  logic [c_GOOD_W-1:0] r_good_cnt, w_good_nxt;
  logic [CNT_W-1:0]    r_period, w_period_nxt;
  logic [CNT_W-1:0]    r_high_time, w_high_nxt;
  logic                r_meas_valid, w_meas_valid_nxt;
  logic                r_err, w_err_nxt;
  logic                r_err_sticky;

  logic                w_rise;
  logic                w_fall_unused;  // falling edge is not needed here
  logic                w_good;

  clk_edge_det u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (mon_clk),
    .rise  (w_rise),
    .fall  (w_fall_unused)
  );

  // Quality of the period that ends at the current rise
`ifdef CLK_DIV_MON_DUTY_CHECK_EN
  assign w_good = (r_cnt == c_DIV) && ((r_hcnt == c_HALF_LO) || (r_hcnt == c_HALF_HI));
`else
  assign w_good = (r_cnt == c_DIV);
`endif

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hcnt_nxt       = r_hcnt;
    w_good_nxt       = r_good_cnt;
    w_period_nxt     = r_period;
    w_high_nxt       = r_high_time;
    w_meas_valid_nxt = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      SEEK: begin
        if (w_rise) begin
          w_cnt_nxt   = CNT_W'(1);
          w_hcnt_nxt  = CNT_W'(1);
          w_state_nxt = MEAS;
        end
      end

      MEAS, LOCKED: begin
        if (w_rise) begin
          // Rise takes priority over a timeout in the same cycle
          w_period_nxt     = r_cnt;
          w_high_nxt       = r_hcnt;
          w_meas_valid_nxt = 1'b1;
          w_cnt_nxt        = CNT_W'(1);
          w_hcnt_nxt       = CNT_W'(1);
          if (w_good) begin
            if (r_state == MEAS) begin
              w_good_nxt = r_good_cnt + 1'b1;
              if (r_good_cnt == c_LOCK_M1) begin
                w_state_nxt = LOCKED;
              end
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = MEAS;
          end
        end else if (r_cnt == c_TIMEOUT) begin
          // mon_clk stopped: no measurement, restart edge search
          w_err_nxt   = 1'b1;
          w_good_nxt  = '0;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
          w_state_nxt = SEEK;
        end else begin
          // r_cnt < c_TIMEOUT here and r_hcnt <= r_cnt, so neither wraps
          w_cnt_nxt = r_cnt + 1'b1;
          if (mon_clk) begin
            w_hcnt_nxt = r_hcnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = SEEK;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SEEK;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_good_cnt   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_good_cnt   <= w_good_nxt;
      r_period     <= w_period_nxt;
      r_high_time  <= w_high_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_err        <= w_err_nxt;
      // Follows the registered err, so it rises one cycle after it
      r_err_sticky <= r_err_sticky | r_err;
    end
  end

  assign meas_valid = r_meas_valid;
  assign period     = r_period;
  assign high_time  = r_high_time;
  assign locked     = (r_state == LOCKED);
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule : clk_div_monitor
`default_nettype wire

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checker for divided clocks, on the receiving side of a clock divider such as the even divide-by-6. It samples a divided clock `mon_clk` that is generated synchronously from `clk`, and measures its period and high time in `clk` cycles. It compares each measurement against the expected divide ratio and reports lock, per-period results and errors. It sits beside each divider instance as an on-chip or bench-level health monitor.

## Interface
- `DIV`, 6: expected divide ratio, must be ≥ 2.
- `LOCK_CNT`, 4: number of consecutive good periods required to assert `locked`, must be ≥ 1.
- `CNT_W`, `$clog2(2*DIV+1)`: width of the internal counters and result outputs.
- `clk` in 1: reference clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mon_clk` in 1: divided clock under test, synchronous to `clk`. No synchronizer is required.
- `meas_valid` out 1: one-cycle pulse when a new period measurement is valid.
- `period` out CNT_W: last measured period, in `clk` cycles.
- `high_time` out CNT_W: last measured high time, in `clk` cycles.
- `locked` out 1: set after `LOCK_CNT` consecutive good periods.
- `err` out 1: one-cycle pulse on a bad period or on a timeout.
- `err_sticky` out 1: set by any `err` pulse; cleared only by reset.

## Operation
- `prev` register holds `mon_clk` from the previous cycle.
- Rising-edge detect: `rise = mon_clk & ~prev`.
- FSM states:
  - SEEK: wait for the first `rise`. On `rise`, set `cnt=1`, set `hcnt=1`, go to MEAS. `locked=0`.
  - MEAS: each cycle without `rise`, increment `cnt`. Also increment `hcnt` when `mon_clk=1`. On `rise`:
    - latch `period=cnt` and `high_time=hcnt`, pulse `meas_valid`;
    - evaluate the period: it is good if `cnt==DIV` (plus the duty check, see Configuration);
    - if good, increment `good_cnt`; reaching `LOCK_CNT` goes to LOCKED;
    - if bad, pulse `err` and clear `good_cnt`;
    - finally reload `cnt=1` and `hcnt=1`.
  - LOCKED: same counting as MEAS, `locked=1`. A bad period pulses `err`, clears `locked` and `good_cnt`, and returns to MEAS.
- Timeout, from MEAS or LOCKED: if `cnt` reaches `2*DIV` with no `rise`:
  - pulse `err` and clear `locked` and `good_cnt`;
  - go to SEEK;
  - do not pulse `meas_valid`.
- Counters saturate at `2*DIV` and never wrap.
- `rise` in the same cycle as timeout: `rise` wins, and the period is evaluated normally.
- `period` and `high_time` hold their values between measurements.

## Timing
- Reset values:
  - `meas_valid=0`, `period=0`, `high_time=0`, `locked=0`, `err=0`, `err_sticky=0`;
  - FSM in SEEK, `prev=0`, all counters 0.
- `rise` detected at clock edge k gives `meas_valid`, `period`, `high_time` and `err` valid in the cycle following edge k (one registered stage).
- `locked` rises in the same cycle as the `meas_valid` of the `LOCK_CNT`-th good period.
- `locked` falls in the same cycle as the `err` pulse.
- `err_sticky` rises one cycle after the first `err`.
- `rst_n` asserted mid-measurement: all outputs clear immediately (asynchronously). After release, the block restarts in SEEK and ignores any partial period.

## Configuration
- `CLK_DIV_MON_DUTY_CHECK_EN` defined:
  - a period is good only if `period==DIV` and `high_time==DIV/2`, rounded down for odd `DIV`;
  - for odd `DIV`, `high_time==DIV/2+1` is also accepted.
- Undefined: only `period==DIV` is checked. `high_time` is still measured and reported.

## Structure
- Package `clk_div_mon_pkg` holds:
  - the FSM state enum typedef (`SEEK`, `MEAS`, `LOCKED`);
  - the default `LOCK_CNT` constant.
- One sub-module, `clk_edge_det`: registers `prev` and outputs `rise` and `fall`, with the same `clk`/`rst_n`. It is reusable by other divider blocks.
- Counters, compare logic and FSM live in the top module.

## Test plan
- Reset: hold `rst_n=0` for 30 ns with `mon_clk` toggling. Expect all outputs 0 and no `meas_valid`.
- Clean divide-by-6, waveform HHHLLL, `DIV=6`:
  - first `meas_valid` one cycle after the second rising edge, with `period=6`, `high_time=3`;
  - `locked=1` with the 4th `meas_valid`; `err` never pulses.
- Glitch after lock: one period of 7 cycles (HHHHLLL). Expect:
  - `period=7`, `err` pulse, `err_sticky=1`, `locked=0`;
  - `locked` reasserts after 4 more good periods, while `err_sticky` stays 1.
- Stuck clock after lock: hold `mon_clk=0`. Expect the `err` pulse when `cnt` reaches 12, `locked=0`, state SEEK and no `meas_valid`. Resuming toggling relocks after 4 periods.
- Duty error, waveform HHHHLL (`period=6`, `high_time=4`):
  - with `CLK_DIV_MON_DUTY_CHECK_EN`: `err` every period, never locked;
  - without it: `locked` after 4 periods and no `err`.
- Reset mid-operation: assert `rst_n` while LOCKED with `err_sticky=1`. Expect all outputs 0 immediately. After release, the first `meas_valid` comes only after two rising edges.
